// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding byte/halfword/word access to a word-wide data memory.
// Sub-word stores are done by read-modify-write of the containing word.
module load_store_unit #(
    parameter int unsigned address_width = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_address,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [31:0] mem_read_data
);

    // Byte-address bits above the attached memory; any set bit is out of range.
    localparam logic [31:0] HiMask = ~((32'd1 << (address_width + 32'd2)) - 32'd1);

    typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_t;

    state_t      state_q, state_d;
    logic        write_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        error_q;
    logic [31:0] word_q;
    logic [31:0] rdata_q;

    logic        accept;
    logic        req_err;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_data;
    logic [31:0] merged;

    assign accept = req_valid && (state_q == StIdle);

    always_comb begin
        req_err = 1'b0;
        case (req_size)
            2'b00:   req_err = 1'b0;
            2'b01:   req_err = req_address[0];
            2'b10:   req_err = |req_address[1:0];
            default: req_err = 1'b1;
        endcase
        if (|(req_address & HiMask)) begin
            req_err = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (req_err) begin
                        state_d = StDone;
                    end else if (req_write && (req_size == 2'b10)) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StRd:    state_d = write_q ? StWr : StDone;
            StWr:    state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    // Lane extraction for loads, taken straight from the memory word in RD.
    always_comb begin
        ld_byte = 8'h00;
        case (addr_q[1:0])
            2'd0: ld_byte = mem_read_data[7:0];
            2'd1: ld_byte = mem_read_data[15:8];
            2'd2: ld_byte = mem_read_data[23:16];
            default: ld_byte = mem_read_data[31:24];
        endcase
        ld_half = addr_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
        case (size_q)
            2'b00:   load_data = {{24{~unsigned_q & ld_byte[7]}}, ld_byte};
            2'b01:   load_data = {{16{~unsigned_q & ld_half[15]}}, ld_half};
            default: load_data = mem_read_data;
        endcase
    end

    always_comb begin
        merged = word_q;
        case (size_q)
            2'b00: begin
                case (addr_q[1:0])
                    2'd0: merged[7:0]   = wdata_q[7:0];
                    2'd1: merged[15:8]  = wdata_q[7:0];
                    2'd2: merged[23:16] = wdata_q[7:0];
                    default: merged[31:24] = wdata_q[7:0];
                endcase
            end
            2'b01: begin
                if (addr_q[1]) begin
                    merged[31:16] = wdata_q[15:0];
                end else begin
                    merged[15:0] = wdata_q[15:0];
                end
            end
            default: merged = wdata_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            write_q    <= 1'b0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            error_q    <= 1'b0;
            word_q     <= 32'h0;
            rdata_q    <= 32'h0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                write_q    <= req_write;
                size_q     <= req_size;
                unsigned_q <= req_unsigned;
                addr_q     <= req_address;
                wdata_q    <= req_wdata;
                error_q    <= req_err;
                rdata_q    <= 32'h0;
            end
            if (state_q == StRd) begin
                word_q <= mem_read_data;
                if (!write_q) begin
                    rdata_q <= load_data;
                end
            end
        end
    end

    assign req_ready      = (state_q == StIdle);
    assign resp_valid     = (state_q == StDone);
    assign resp_error     = (state_q == StDone) && error_q;
    assign resp_rdata     = (state_q == StDone) ? rdata_q : 32'h0;
    assign mem_read       = (state_q == StRd);
    assign mem_write      = (state_q == StWr);
    assign mem_address    = {addr_q[31:2], 2'b00};
    assign mem_write_data = merged;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomised bench for load_store_unit against a word-array reference model of the memory.
module tb_load_store_unit;

    localparam int AW = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_address;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_read_data;

    logic [31:0] mem [0:(1<<AW)-1];
    logic [31:0] ref_mem [0:(1<<AW)-1];

    int n_checks = 0;
    int n_errors = 0;
    int last_lat;
    int last_acc;
    logic [31:0] last_wdata;
    logic        last_err;

    load_store_unit #(.address_width(AW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_address(req_address), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_error(resp_error), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_write(mem_write), .mem_read(mem_read),
        .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    assign mem_read_data = mem[mem_address[AW+1:2]];
    always @(posedge clk) begin
        if (mem_write) mem[mem_address[AW+1:2]] <= mem_write_data;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic do_txn(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd, output logic [31:0] got);
        logic        e_err;
        logic [31:0] old, e_rdata, e_word, m, v;
        int          sh, e_lat, e_rd, e_wr, n_rd, n_wr, lat;
        e_err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)
                || (a >= (32'd4 << AW));
        old = ref_mem[a[AW+1:2]];
        e_rdata = 32'h0;
        e_word = old;
        m  = (sz == 2'd0) ? 32'hFF : 32'hFFFF;
        sh = (sz == 2'd0) ? 8 * int'(a[1:0]) : 16 * int'(a[1]);
        if (e_err) begin
            e_lat = 1; e_rd = 0; e_wr = 0;
        end else if (!wr) begin
            e_lat = 2; e_rd = 1; e_wr = 0;
            if (sz == 2'd2) begin
                e_rdata = old;
            end else begin
                v = (old >> sh) & m;
                if (!uns && (sz == 2'd0) && v[7])  v = v | 32'hFFFFFF00;
                if (!uns && (sz == 2'd1) && v[15]) v = v | 32'hFFFF0000;
                e_rdata = v;
            end
        end else if (sz == 2'd2) begin
            e_lat = 2; e_rd = 0; e_wr = 1; e_word = wd;
        end else begin
            e_lat = 3; e_rd = 1; e_wr = 1;
            e_word = (old & ~(m << sh)) | ((wd & m) << sh);
        end

        got = 32'h0;
        @(negedge clk);
        req_write = wr; req_size = sz; req_unsigned = uns; req_address = a; req_wdata = wd;
        req_valid = 1'b1;
        chk("ready_idle", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        // Hold junk with req_valid high while busy: it must be ignored.
        req_write = 1'($urandom); req_size = 2'($urandom); req_address = $urandom;
        req_wdata = $urandom;
        n_rd = 0; n_wr = 0; lat = 0;
        for (int c = 1; c <= 6; c++) begin
            if (mem_read || mem_write) begin
                chk("strobe_excl", {31'b0, mem_read & mem_write}, 32'd0);
                chk("mem_addr", mem_address, {a[31:2], 2'b00});
            end
            if (mem_read) n_rd++;
            if (mem_write) begin
                n_wr++;
                last_wdata = mem_write_data;
                chk("mem_wdata", mem_write_data, e_word);
            end
            if (resp_valid) begin
                lat = c;
                got = resp_rdata;
                last_err = resp_error;
                chk("resp_rdata", resp_rdata, e_rdata);
                chk("resp_error", {31'b0, resp_error}, {31'b0, e_err});
                req_valid = 1'b0;
                break;
            end
            chk("ready_busy", {31'b0, req_ready}, 32'd0);
            @(negedge clk);
        end
        req_valid = 1'b0;
        if (lat == 0) begin
            n_checks++; n_errors++;
            $display("FAIL resp_timeout: got no resp_valid expected one within 6 cycles");
        end else begin
            chk("latency", 32'(lat), 32'(e_lat));
        end
        chk("n_reads", 32'(n_rd), 32'(e_rd));
        chk("n_writes", 32'(n_wr), 32'(e_wr));
        last_lat = lat;
        last_acc = n_rd + n_wr;
        @(negedge clk);
        chk("resp_one_cycle", {31'b0, resp_valid}, 32'd0);
        chk("ready_after", {31'b0, req_ready}, 32'd1);
        if (wr && !e_err) ref_mem[a[AW+1:2]] = e_word;
    endtask

    initial begin
        logic [31:0] got, a, w;
        logic [1:0]  sz;
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] got, a, wd;
        logic [1:0]  sz;
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[4] = 32'h8899AABB;  ref_mem[4] = 32'h8899AABB;
        mem[1023] = 32'hCAFEF00D; ref_mem[1023] = 32'hCAFEF00D;
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_address = 32'h0; req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_error", {31'b0, resp_error}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_mem_rw", {30'b0, mem_read, mem_write}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", {31'b0, req_ready}, 32'd1);

        do_txn(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, got);
        chk("lit_lb", got, 32'hFFFFFF88);
        chk("lit_lb_lat", 32'(last_lat), 32'd2);
        do_txn(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, got);
        chk("lit_lbu", got, 32'h00000088);
        do_txn(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, got);
        chk("lit_lh", got, 32'hFFFF8899);
        do_txn(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, got);
        chk("lit_lhu", got, 32'h00008899);
        do_txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, got);
        chk("lit_lw", got, 32'h8899AABB);
        do_txn(1'b1, 2'd0, 1'b0, 32'h11, 32'h12345655, got);
        chk("lit_sb_wdata", last_wdata, 32'h889955BB);
        chk("lit_sb_lat", 32'(last_lat), 32'd3);
        do_txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, got);
        chk("lit_lw_after_sb", got, 32'h889955BB);
        do_txn(1'b0, 2'd1, 1'b0, 32'h11, 32'h0, got);
        chk("lit_lh_mis_err", {31'b0, last_err}, 32'd1);
        chk("lit_lh_mis_lat", 32'(last_lat), 32'd1);
        do_txn(1'b1, 2'd2, 1'b0, 32'h12, 32'hDEADBEEF, got);
        chk("lit_sw_mis_err", {31'b0, last_err}, 32'd1);
        chk("lit_sw_mis_acc", 32'(last_acc), 32'd0);
        do_txn(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, got);
        chk("lit_size3_err", {31'b0, last_err}, 32'd1);
        do_txn(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, got);
        chk("lit_oor_err", {31'b0, last_err}, 32'd1);
        chk("lit_oor_acc", 32'(last_acc), 32'd0);
        do_txn(1'b0, 2'd2, 1'b0, 32'hFFC, 32'h0, got);
        chk("lit_top_word", got, 32'hCAFEF00D);

        // Reset while a halfword store is in RD: no write, no response.
        @(negedge clk);
        req_write = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
        req_address = 32'h10; req_wdata = 32'h0000ABCD; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_mid_in_rd", {31'b0, mem_read}, 32'd1);
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_mid_no_write", {31'b0, mem_write}, 32'd0);
            chk("rst_mid_no_resp", {31'b0, resp_valid}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_mid_no_write2", {31'b0, mem_write}, 32'd0);
        do_txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, got);
        chk("lit_word_unchanged", got, 32'h889955BB);

        for (int i = 0; i < 300; i++) begin
            sz = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 9))
                0:       a = $urandom;
                1, 2, 3: a = 32'($urandom_range(0, 4095));
                default: a = 32'($urandom_range(0, 63));
            endcase
            if ($urandom_range(0, 9) < 7) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            wd = $urandom;
            do_txn(1'($urandom), sz, 1'($urandom), a, wd, got);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
